// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD -> binary converter.
// Holds the sizing parameters, the FSM state encoding, the digit/adjust
// constants shared with the binary -> BCD display path, and a digit check helper.
package bcd_to_bin_pkg;

    localparam int DIGITS = 8;
    localparam int BIN_W  = 27;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W);

    localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
    localparam logic [3:0] BCD_ADJ         = 4'd3;
    localparam logic [3:0] BCD_ADJ_THR_B2D = 4'd5;
    localparam logic [3:0] BCD_ADJ_THR_D2B = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True when every packed digit is a legal decimal digit.
    function automatic logic bcd_is_valid(input logic [BCD_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > BCD_DIGIT_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/done handshake bundle for bcd_to_bin.
//   start, bcd_in          : request side (master drives)
//   busy, done, err, bin_out : response side (converter drives)
interface bcd_to_bin_if;
    import bcd_to_bin_pkg::*;

    logic             start;
    logic [BCD_W-1:0] bcd_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [BIN_W-1:0] bin_out;

    modport master (output start, bcd_in, input busy, done, err, bin_out);
    modport slave  (input start, bcd_in, output busy, done, err, bin_out);

endinterface

// File: rtl/bcd_to_bin_nibble_sub3.sv
// Per-digit correction for reverse double dabble.
//   nib_in  : one BCD nibble after the right shift
//   nib_out : nib_in - 3 when nib_in >= 8, else nib_in (4-bit, no borrow out)
module bcd_nibble_sub3
    import bcd_to_bin_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = (nib_in >= BCD_ADJ_THR_D2B) ? (nib_in - BCD_ADJ) : nib_in;

endmodule

// File: rtl/bcd_to_bin.sv
// Packed 8-digit BCD to unsigned binary converter, one shift per clock.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : bcd_to_bin_if slave (start/bcd_in in; busy/done/err/bin_out out)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; digits checked on accept
// ST_SHIFT | one right shift + per-digit -3 correction per clock, BIN_W total
// ST_DONE  | done pulse; with err_pend set, first spends one cycle latching err
module bcd_to_bin
    import bcd_to_bin_pkg::*;
(
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    bcd_to_bin_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t           state, state_nx;
    logic [BCD_W-1:0] bcd_r, bcd_nx;
    logic [BIN_W-1:0] bin_r, bin_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             err_pend, err_pend_nx;
    logic             done_r, done_nx;
    logic             err_r, err_nx;
    logic [BIN_W-1:0] bin_out_r, bin_out_nx;

    // Right shift of the whole work register: bcd_r LSB falls into bin_r MSB.
    logic [BCD_W-1:0] bcd_shift, bcd_adj;
    logic [BIN_W-1:0] bin_shift;

    assign bcd_shift = {1'b0, bcd_r[BCD_W-1:1]};
    assign bin_shift = {bcd_r[0], bin_r[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
        bcd_nibble_sub3 u_sub3 (
            .nib_in  (bcd_shift[4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            bcd_r     <= '0;
            bin_r     <= '0;
            cnt       <= '0;
            err_pend  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            bin_out_r <= '0;
        end else begin
            state     <= state_nx;
            bcd_r     <= bcd_nx;
            bin_r     <= bin_nx;
            cnt       <= cnt_nx;
            err_pend  <= err_pend_nx;
            done_r    <= done_nx;
            err_r     <= err_nx;
            bin_out_r <= bin_out_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bcd_nx      = bcd_r;
        bin_nx      = bin_r;
        cnt_nx      = cnt;
        err_pend_nx = err_pend;
        done_nx     = 1'b0;
        err_nx      = err_r;
        bin_out_nx  = bin_out_r;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bcd_is_valid(bus.bcd_in)) begin
                        bcd_nx   = bus.bcd_in;
                        bin_nx   = '0;
                        cnt_nx   = '0;
                        state_nx = ST_SHIFT;
                    end else begin
                        err_pend_nx = 1'b1;
                        state_nx    = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_nx = bcd_adj;
                bin_nx = bin_shift;
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    // Result taken from the value produced by this final shift.
                    state_nx   = ST_DONE;
                    done_nx    = 1'b1;
                    err_nx     = 1'b0;
                    bin_out_nx = bin_shift;
                end
            end
            ST_DONE: begin
                // An invalid request lingers one cycle so err/bin_out change
                // on the same edge that raises done.
                if (err_pend) begin
                    err_pend_nx = 1'b0;
                    done_nx     = 1'b1;
                    err_nx      = 1'b1;
                    bin_out_nx  = '0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.bin_out = bin_out_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;
    import bcd_to_bin_pkg::*;

    localparam int LAT_VALID   = BIN_W;
    localparam int LAT_INVALID = 1;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic             err;
        logic [BIN_W-1:0] bin;
        int               cyc;
    } exp_t;

    exp_t sb[$];

    bcd_to_bin_if bus ();

    bcd_to_bin dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal reference: digits weighted by powers of ten.
    function automatic void model(input logic [BCD_W-1:0] v, output logic err, output logic [BIN_W-1:0] bin);
        longint unsigned acc;
        int unsigned     d;
        acc = 0;
        err = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = (v >> (4 * i)) & 32'hF;
            if (d > 9) err = 1'b1;
            acc = acc * 10 + d;
        end
        bin = err ? '0 : BIN_W'(acc);
    endfunction

    // Monitor: pops the expected response whenever the DUT signals done.
    always @(negedge sys_clk) begin
        if (sys_rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bin_out", bus.bin_out, e.bin);
                chk("err", bus.err, e.err);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic issue(input logic [BCD_W-1:0] v, input bit expect_result);
        exp_t e;
        model(v, e.err, e.bin);
        e.cyc = cyc + 1 + (e.err ? LAT_INVALID : LAT_VALID);
        if (expect_result) sb.push_back(e);
        bus.start  = 1'b1;
        bus.bcd_in = v;
        @(negedge sys_clk);
        bus.start  = 1'b0;
    endtask

    // Returns at the negedge after the done pulse.
    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
        @(negedge sys_clk);
    endtask

    task automatic run(input logic [BCD_W-1:0] v);
        issue(v, 1'b1);
        wait_done();
    endtask

    function automatic logic [BCD_W-1:0] rand_bcd();
        logic [BCD_W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_bin_out", bus.bin_out, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        run(32'h99999999);
        chk("ref_99999999", sb.size(), 0);
        run(32'h00000000);
        run(32'h12345678);
        run(32'h00000001);
        run(32'h0000A123);
        chk("err_held", bus.err, 1);
        run(32'h00000007);
        chk("bin_held", bus.bin_out, 7);

        // Second start mid-conversion must be dropped.
        issue(32'h00654321, 1'b1);
        repeat (9) @(negedge sys_clk);
        bus.start  = 1'b1;
        bus.bcd_in = 32'h00000099;
        @(negedge sys_clk);
        bus.start  = 1'b0;
        wait_done();
        repeat (30) @(negedge sys_clk);
        chk("ignored_start_result", bus.bin_out, 654321);

        // Leave err set, then reset in the middle of a conversion.
        run(32'hF0000000);
        issue(32'h87654321, 1'b0);
        repeat (14) @(negedge sys_clk);
        chk("mid_busy", bus.busy, 1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        chk("mrst_err", bus.err, 0);
        chk("mrst_bin_out", bus.bin_out, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        run(32'h00000042);
        chk("after_rst_bin", bus.bin_out, 42);

        for (int i = 0; i < 1500; i++) run(rand_bcd());

        repeat (5) @(negedge sys_clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
